// File: rtl/qc_pkg.sv
// Shared definitions for the quantum-state arithmetic blocks: default
// vector geometry and the normaliser's FSM state encoding.
package qc_pkg;

    localparam int DEF_N = 1;
    localparam int DEF_W = 8;
    localparam int DEF_Q = 6;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        SQRT,
        RECIP,
        SCALE,
        DONE
    } norm_state_e;

endpackage

// File: rtl/seq_div.sv
// Unsigned restoring divider, one quotient bit per cycle. done is high during
// the cycle whose closing edge writes the final quotient bit.
module seq_div #(
    parameter int DW = 13,
    parameter int VW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic          done
);
    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] work;
    logic [VW-1:0] rem;
    logic [VW-1:0] dvs;
    logic [CW-1:0] cnt;
    logic [VW:0]   rem_sh;
    logic [VW:0]   diff;
    logic          fits;

    always_comb begin
        rem_sh = {rem, work[DW-1]};
        diff   = rem_sh - {1'b0, dvs};
        fits   = (rem_sh >= {1'b0, dvs});
    end

    // work shifts the dividend out at the top and the quotient in at the bottom
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work <= '0;
            rem  <= '0;
            dvs  <= '0;
            cnt  <= '0;
        end else if (start) begin
            work <= dividend;
            rem  <= '0;
            dvs  <= divisor;
            cnt  <= CW'(DW);
        end else if (cnt != '0) begin
            work <= {work[DW-2:0], fits};
            rem  <= fits ? diff[VW-1:0] : rem_sh[VW-1:0];
            cnt  <= cnt - CW'(1);
        end
    end

    assign quotient = work;
    assign done     = (cnt == CW'(1));

endmodule

// File: rtl/state_normalizer.sv
// Normalises a packed complex state vector: sum of squares, bit-serial integer
// square root, reciprocal by sequential division, then per-amplitude rescale.
module state_normalizer
    import qc_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W,
    parameter int Q = DEF_Q
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [2*W*(2**N)-1:0] in_state,
    output logic [2*W*(2**N)-1:0] out_state,
    output logic                  busy,
    output logic                  done,
    output logic                  zero_norm,
    output logic                  overflow
);
    localparam int AMPS = 2**N;
    localparam int AW   = 2*W;
    localparam int VW   = AW*AMPS;
    localparam int SW   = 2*W + N;
    localparam int SQW  = (SW + 1) / 2;
    localparam int IW   = (N > 0) ? N : 1;
    localparam int SIW  = (SQW > 1) ? $clog2(SQW) : 1;
    localparam int QW   = 2*Q + 1;
    localparam int PW   = W + QW + 1;
    localparam logic [QW-1:0]        DIVIDEND = QW'(1) << (2*Q);
    localparam logic signed [PW-1:0] SAT_HI   = PW'((2**(W-1)) - 1);
    localparam logic signed [PW-1:0] SAT_LO   = ~SAT_HI;

    norm_state_e state, state_n;

    logic [VW-1:0]          vec;
    logic [IW-1:0]          idx;
    logic                   idx_last;
    logic [SW-1:0]          s;
    logic [SW-1:0]          s_sum;
    logic [SQW-1:0]         r;
    logic [SQW-1:0]         r_n;
    logic [SQW+1:0]         rem;
    logic [SQW+1:0]         rem_n;
    logic [SIW-1:0]         sq_idx;
    logic [2*SQW-1:0]       s_pad;
    logic [SQW+3:0]         rem_sh;
    logic [SQW+3:0]         trial;
    logic [QW-1:0]          inv;
    logic                   div_start;
    logic                   div_done;
    logic [AW-1:0]          amp;
    logic signed [W-1:0]    amp_re;
    logic signed [W-1:0]    amp_im;
    logic signed [AW-1:0]   re_sq;
    logic signed [AW-1:0]   im_sq;
    logic signed [QW:0]     inv_s;
    logic signed [PW-1:0]   p_re;
    logic signed [PW-1:0]   p_im;
    logic [W:0]             sat_re;
    logic [W:0]             sat_im;

    // Returns {saturated, value} for a product already scaled by 2**Q.
    function automatic logic [W:0] saturate(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] sh;
        sh = v >>> Q;
        if (sh > SAT_HI) return {1'b1, SAT_HI[W-1:0]};
        if (sh < SAT_LO) return {1'b1, SAT_LO[W-1:0]};
        return {1'b0, sh[W-1:0]};
    endfunction

    assign amp      = vec[int'(idx)*AW +: AW];
    assign amp_re   = amp[AW-1:W];
    assign amp_im   = amp[W-1:0];
    assign idx_last = (idx == IW'(AMPS - 1));

    assign re_sq = amp_re * amp_re;
    assign im_sq = amp_im * amp_im;
    assign s_sum = s + SW'($unsigned(re_sq)) + SW'($unsigned(im_sq));

    assign inv_s  = {1'b0, inv};
    assign p_re   = amp_re * inv_s;
    assign p_im   = amp_im * inv_s;
    assign sat_re = saturate(p_re);
    assign sat_im = saturate(p_im);

    // One radicand bit pair per cycle, most significant pair first.
    always_comb begin
        s_pad  = (2*SQW)'(s);
        rem_sh = {rem, s_pad[2*int'(sq_idx) +: 2]};
        trial  = (SQW+4)'({r, 2'b01});
        if (rem_sh >= trial) begin
            rem_n = (SQW+2)'(rem_sh - trial);
            r_n   = {r[SQW-2:0], 1'b1};
        end else begin
            rem_n = rem_sh[SQW+1:0];
            r_n   = {r[SQW-2:0], 1'b0};
        end
    end

    seq_div #(
        .DW(QW),
        .VW(SQW)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend (DIVIDEND),
        .divisor  (r_n),
        .quotient (inv),
        .done     (div_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // The divider is launched from the last root step so RECIP is exactly its length.
    always_comb begin
        state_n   = state;
        div_start = 1'b0;
        case (state)
            IDLE:    if (start) state_n = ACCUM;
            ACCUM:   if (idx_last) state_n = (s_sum == '0) ? DONE : SQRT;
            SQRT: begin
                if (sq_idx == '0) begin
                    state_n   = RECIP;
                    div_start = 1'b1;
                end
            end
            RECIP:   if (div_done) state_n = SCALE;
            SCALE:   if (idx_last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec       <= '0;
            idx       <= '0;
            s         <= '0;
            r         <= '0;
            rem       <= '0;
            sq_idx    <= '0;
            out_state <= '0;
            zero_norm <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec       <= in_state;
                        idx       <= '0;
                        s         <= '0;
                        zero_norm <= 1'b0;
                        overflow  <= 1'b0;
                    end
                end
                ACCUM: begin
                    s   <= s_sum;
                    idx <= idx_last ? '0 : idx + IW'(1);
                    if (idx_last) begin
                        if (s_sum == '0) begin
                            out_state <= '0;
                            zero_norm <= 1'b1;
                        end else begin
                            r      <= '0;
                            rem    <= '0;
                            sq_idx <= SIW'(SQW - 1);
                        end
                    end
                end
                SQRT: begin
                    r   <= r_n;
                    rem <= rem_n;
                    if (sq_idx != '0) sq_idx <= sq_idx - SIW'(1);
                end
                SCALE: begin
                    out_state[int'(idx)*AW +: AW] <= {sat_re[W-1:0], sat_im[W-1:0]};
                    overflow <= overflow | sat_re[W] | sat_im[W];
                    idx      <= idx_last ? '0 : idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule

// File: tb/tb_state_normalizer.sv
// Directed bench for state_normalizer: default geometry, a four-amplitude
// instance and a Q=7 instance where a unit amplitude saturates.
module tb_state_normalizer;

    typedef struct {
        logic [31:0] vin;
        logic [31:0] vout;
        bit          zero;
        bit          ovf;
        int          lat;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start1, start2, start3;
    logic [31:0] in1, in3, out1, out3;
    logic [63:0] in2, out2;
    logic        busy1, busy2, busy3;
    logic        done1, done2, done3;
    logic        zero1, zero2, zero3;
    logic        ovf1, ovf2, ovf3;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    state_normalizer u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .in_state(in1), .out_state(out1),
        .busy(busy1), .done(done1), .zero_norm(zero1), .overflow(ovf1)
    );

    state_normalizer #(.N(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_state(in2), .out_state(out2),
        .busy(busy2), .done(done2), .zero_norm(zero2), .overflow(ovf2)
    );

    state_normalizer #(.Q(7)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .in_state(in3), .out_state(out3),
        .busy(busy3), .done(done3), .zero_norm(zero3), .overflow(ovf3)
    );

    // Reference normaliser working on whole integers (W = 8 components).
    function automatic logic [63:0] ref_norm(input int n, input int q, input logic [63:0] v,
                                             output bit zero, output bit ovf);
        logic [63:0] res;
        longint      s, r, inv, o;
        byte         c;
        res  = '0;
        zero = 1'b0;
        ovf  = 1'b0;
        s    = 0;
        for (int k = 0; k < 2*(2**n); k++) begin
            c = v[8*k +: 8];
            s += longint'(c) * longint'(c);
        end
        if (s == 0) begin
            zero = 1'b1;
            return res;
        end
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        inv = (longint'(1) << (2*q)) / r;
        for (int k = 0; k < 2*(2**n); k++) begin
            c = v[8*k +: 8];
            o = (longint'(c) * inv) >>> q;
            if (o > 127) begin
                o   = 127;
                ovf = 1'b1;
            end else if (o < -128) begin
                o   = -128;
                ovf = 1'b1;
            end
            res[8*k +: 8] = o[7:0];
        end
        return res;
    endfunction

    function automatic bit pick_done(input int sel);
        if (sel == 1) return done1;
        if (sel == 2) return done2;
        return done3;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the target idle; returns at the negedge showing done.
    task automatic applyStimulus(input int sel, input logic [63:0] v, output int lat, output bit busy_seen);
        int cnt;
        case (sel)
            1:       begin in1 = v[31:0]; start1 = 1'b1; end
            2:       begin in2 = v;       start2 = 1'b1; end
            default: begin in3 = v[31:0]; start3 = 1'b1; end
        endcase
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        busy_seen = (sel == 1) ? busy1 : (sel == 2) ? busy2 : busy3;
        cnt = 1;
        while (!pick_done(sel) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        lat = cnt;
    endtask

    initial begin
        vec_t        tbl[9];
        int          lat;
        int          dones;
        int          first;
        bit          bsy;
        bit          zr;
        bit          ov;
        bit          saw;
        logic [63:0] exp;

        tbl[0] = '{32'h4000_4000, 32'h2D00_2D00, 1'b0, 1'b0, 27};
        tbl[1] = '{32'h0000_0800, 32'h0000_4000, 1'b0, 1'b0, 27};
        tbl[2] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 3};
        tbl[3] = '{32'h0000_C000, 32'h0000_C000, 1'b0, 1'b0, 27};
        tbl[4] = '{32'h0000_0304, 32'h0000_2633, 1'b0, 1'b0, 27};
        tbl[5] = '{32'h0004_FD00, 32'h0033_D900, 1'b0, 1'b0, 27};
        tbl[6] = '{32'h1010_10F0, 32'h2020_20E0, 1'b0, 1'b0, 27};
        tbl[7] = '{32'h8080_8080, 32'hE0E0_E0E0, 1'b0, 1'b0, 27};
        tbl[8] = '{32'h0000_0101, 32'h0000_4040, 1'b0, 1'b0, 27};

        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        start3 = 1'b0;
        in1    = '0;
        in2    = '0;
        in3    = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset out", 64'(out1), 64'h0);
        checkOutput("reset busy", 64'(busy1), 64'h0);
        checkOutput("reset done", 64'(done1), 64'h0);
        checkOutput("reset zero_norm", 64'(zero1), 64'h0);
        checkOutput("reset overflow", 64'(ovf1), 64'h0);
        checkOutput("reset out n2", out2, 64'h0);
        checkOutput("reset out q7", 64'(out3), 64'h0);

        // Release and start on the same negedge: the first edge must accept.
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 64'(tbl[i].vin), lat, bsy);
            checkOutput($sformatf("v%0d busy", i), 64'(bsy), 64'h1);
            checkOutput($sformatf("v%0d latency", i), 64'(lat), 64'(tbl[i].lat));
            checkOutput($sformatf("v%0d out", i), 64'(out1), 64'(tbl[i].vout));
            checkOutput($sformatf("v%0d zero_norm", i), 64'(zero1), 64'(tbl[i].zero));
            checkOutput($sformatf("v%0d overflow", i), 64'(ovf1), 64'(tbl[i].ovf));
            @(negedge clk);
            checkOutput($sformatf("v%0d done width", i), 64'(done1), 64'h0);
            checkOutput($sformatf("v%0d idle", i), 64'(busy1), 64'h0);
        end

        // Start re-pulsed with a different vector during SQRT and RECIP.
        in1    = 32'h4000_4000;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        dones  = 0;
        first  = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done1) begin
                dones++;
                if (first == 0) first = c;
            end
            if (c == 5 || c == 15) begin
                in1    = 32'h0000_0800;
                start1 = 1'b1;
            end else begin
                start1 = 1'b0;
            end
            @(negedge clk);
        end
        start1 = 1'b0;
        checkOutput("repulse done count", 64'(dones), 64'd1);
        checkOutput("repulse latency", 64'(first), 64'd27);
        checkOutput("repulse out", 64'(out1), 64'h2D00_2D00);

        // Reset asserted mid-SQRT, then a fresh run right after release.
        in1    = 32'h0000_0800;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("hold out mid-run", 64'(out1), 64'h2D00_2D00);
        checkOutput("busy mid-run", 64'(busy1), 64'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst out", 64'(out1), 64'h0);
        checkOutput("midrst busy", 64'(busy1), 64'h0);
        checkOutput("midrst done", 64'(done1), 64'h0);
        saw = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            saw = saw | done1;
        end
        checkOutput("midrst no done", 64'(saw), 64'h0);
        rst_n = 1'b1;
        applyStimulus(1, 64'h0000_0800, lat, bsy);
        checkOutput("post-rst latency", 64'(lat), 64'd27);
        checkOutput("post-rst out", 64'(out1), 64'h0000_4000);
        @(negedge clk);

        // Four-amplitude instance against the reference model.
        applyStimulus(2, 64'h2000_2000_2000_2000, lat, bsy);
        exp = ref_norm(2, 6, 64'h2000_2000_2000_2000, zr, ov);
        checkOutput("n2 equal latency", 64'(lat), 64'd31);
        checkOutput("n2 equal out", out2, exp);
        checkOutput("n2 equal overflow", 64'(ovf2), 64'(ov));
        @(negedge clk);
        applyStimulus(2, 64'hF010_0C00_0305_7F81, lat, bsy);
        exp = ref_norm(2, 6, 64'hF010_0C00_0305_7F81, zr, ov);
        checkOutput("n2 mixed latency", 64'(lat), 64'd31);
        checkOutput("n2 mixed out", out2, exp);
        checkOutput("n2 mixed zero_norm", 64'(zero2), 64'(zr));
        checkOutput("n2 mixed overflow", 64'(ovf2), 64'(ov));
        @(negedge clk);

        // Q=7: a lone unit amplitude maps to +1.0, which saturates.
        applyStimulus(3, 64'h0000_4000, lat, bsy);
        checkOutput("q7 sat latency", 64'(lat), 64'd29);
        checkOutput("q7 sat out", 64'(out3), 64'h0000_7F00);
        checkOutput("q7 sat overflow", 64'(ovf3), 64'h1);
        @(negedge clk);
        applyStimulus(3, 64'h0000_0304, lat, bsy);
        checkOutput("q7 plain out", 64'(out3), 64'h0000_4C66);
        checkOutput("q7 overflow cleared", 64'(ovf3), 64'h0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
